// File: rtl/read_responder.sv
// Read-stage data responder: splits a 1..8 byte read into up to three aligned dword beats.
// Optional bus timeout is compiled in with READ_RESPONDER_TIMEOUT_EN.
module read_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [31:0] rd_address,
  input  logic [3:0]  rd_length,
  input  logic        rd_abort,
  output logic        rd_done,
  output logic [31:0] read_4,
  output logic [63:0] read_8,
  output logic        rd_busy,
  output logic        rd_bus_error,
  output logic [29:0] bus_address,
  output logic        bus_read,
  output logic [3:0]  bus_byteenable,
  input  logic        bus_waitrequest,
  input  logic        bus_readdatavalid,
  input  logic [31:0] bus_readdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t      state_r, state_next_s;
  logic [1:0]  off_r, beats_r, beat_idx_r;
  logic [3:0]  len_r;
  logic        abort_r;
  logic [95:0] buf_r;

  logic        accept_s, beat_valid_s, last_beat_s, timeout_s, abort_any_s;
  logic [1:0]  acc_off_s, acc_beats_s;
  logic [3:0]  acc_len_s, acc_sum_s;
  logic [31:0] beat_data_s;
  logic [95:0] buf_next_s;

  logic        abort_next_s, rd_done_next_s;
  logic [1:0]  beat_idx_next_s;
  logic [29:0] bus_address_next_s;
  logic [3:0]  bus_byteenable_next_s;
  logic [63:0] read_8_next_s;

  function automatic logic [3:0] eff_len(input logic [3:0] l);
    logic [3:0] r;
    if ((l == 4'd0) || (l > 4'd8)) r = 4'd8;
    else r = l;
    return r;
  endfunction

  // Byte lanes of beat idx out of beats, for a request starting at off with len bytes
  function automatic logic [3:0] beat_be(input logic [1:0] idx, input logic [1:0] beats,
                                         input logic [1:0] off, input logic [3:0] len);
    logic [3:0] last_byte, lo, hi, be;
    last_byte = {2'b00, off} + len - 4'd1;
    lo = 4'hF << off;
    hi = 4'hF >> (2'd3 - last_byte[1:0]);
    if (beats == 2'd1) be = lo & hi;
    else if (idx == 2'd0) be = lo;
    else if (idx == beats - 2'd1) be = hi;
    else be = 4'hF;
    return be;
  endfunction

  function automatic logic [63:0] extract(input logic [95:0] b, input logic [1:0] off,
                                          input logic [3:0] len);
    logic [95:0] sh;
    logic [63:0] mask;
    sh = b >> {off, 3'b000};
    if (len >= 4'd8) mask = {64{1'b1}};
    else mask = (64'd1 << {len, 3'b000}) - 64'd1;
    return sh[63:0] & mask;
  endfunction

  assign acc_off_s   = rd_address[1:0];
  assign acc_len_s   = eff_len(rd_length);
  assign acc_sum_s   = {2'b00, acc_off_s} + acc_len_s + 4'd3;
  assign acc_beats_s = acc_sum_s[3:2];
  assign accept_s    = (state_r == IDLE) && rd_req && !rd_abort;
  assign last_beat_s = (beat_idx_r == beats_r - 2'd1);
  assign abort_any_s = abort_r | rd_abort;

`ifdef READ_RESPONDER_TIMEOUT_EN
  logic [7:0] wait_cnt_r;

  // Counts consecutive WAIT cycles without data; zero whenever WAIT is entered
  always_ff @(posedge clk) begin
    if (rst) wait_cnt_r <= 8'd0;
    else if ((state_r == WAIT) && !bus_readdatavalid) wait_cnt_r <= wait_cnt_r + 8'd1;
    else wait_cnt_r <= 8'd0;
  end

  assign timeout_s = (state_r == WAIT) && !bus_readdatavalid && (wait_cnt_r == 8'd254);
`else
  assign timeout_s = 1'b0;
`endif

  // Beat capture; a timed-out beat reads as all ones
  always_comb begin
    beat_valid_s = (state_r == WAIT) && (bus_readdatavalid || timeout_s);
    beat_data_s  = bus_readdatavalid ? bus_readdata : 32'hFFFF_FFFF;
    buf_next_s   = buf_r;
    if (beat_valid_s) begin
      case (beat_idx_r)
        2'd0:    buf_next_s[31:0]  = beat_data_s;
        2'd1:    buf_next_s[63:32] = beat_data_s;
        2'd2:    buf_next_s[95:64] = beat_data_s;
        default: buf_next_s        = buf_r;
      endcase
    end else begin
      buf_next_s = buf_r;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else state_r <= state_next_s;
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = accept_s ? REQ : IDLE;
      REQ:     state_next_s = bus_waitrequest ? REQ : WAIT;
      WAIT: begin
        if (beat_valid_s) state_next_s = last_beat_s ? DONE : REQ;
        else state_next_s = WAIT;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and request context
  always_comb begin
    abort_next_s          = abort_r;
    rd_done_next_s        = 1'b0;
    beat_idx_next_s       = beat_idx_r;
    bus_address_next_s    = bus_address;
    bus_byteenable_next_s = bus_byteenable;
    read_8_next_s         = read_8;
    case (state_r)
      IDLE: begin
        abort_next_s = 1'b0;
        if (accept_s) begin
          beat_idx_next_s       = 2'd0;
          bus_address_next_s    = rd_address[31:2];
          bus_byteenable_next_s = beat_be(2'd0, acc_beats_s, acc_off_s, acc_len_s);
        end else begin
          beat_idx_next_s = beat_idx_r;
        end
      end
      REQ: abort_next_s = abort_any_s;
      WAIT: begin
        abort_next_s = abort_any_s;
        if (beat_valid_s && last_beat_s) begin
          rd_done_next_s = !abort_any_s;
          read_8_next_s  = abort_any_s ? read_8 : extract(buf_next_s, off_r, len_r);
        end else if (beat_valid_s) begin
          beat_idx_next_s       = beat_idx_r + 2'd1;
          bus_address_next_s    = bus_address + 30'd1;
          bus_byteenable_next_s = beat_be(beat_idx_r + 2'd1, beats_r, off_r, len_r);
        end else begin
          beat_idx_next_s = beat_idx_r;
        end
      end
      DONE:    abort_next_s = 1'b0;
      default: abort_next_s = 1'b0;
    endcase
  end

  // Registered outputs and request context
  always_ff @(posedge clk) begin
    if (rst) begin
      off_r          <= 2'd0;
      len_r          <= 4'd0;
      beats_r        <= 2'd0;
      beat_idx_r     <= 2'd0;
      abort_r        <= 1'b0;
      buf_r          <= 96'd0;
      bus_read       <= 1'b0;
      bus_address    <= 30'd0;
      bus_byteenable <= 4'd0;
      rd_done        <= 1'b0;
      rd_busy        <= 1'b0;
      rd_bus_error   <= 1'b0;
      read_4         <= 32'd0;
      read_8         <= 64'd0;
    end else begin
      if (accept_s) begin
        off_r   <= acc_off_s;
        len_r   <= acc_len_s;
        beats_r <= acc_beats_s;
      end
      beat_idx_r     <= beat_idx_next_s;
      abort_r        <= abort_next_s;
      buf_r          <= buf_next_s;
      bus_read       <= (state_next_s == REQ);
      bus_address    <= bus_address_next_s;
      bus_byteenable <= bus_byteenable_next_s;
      rd_done        <= rd_done_next_s;
      rd_busy        <= (state_next_s != IDLE);
      rd_bus_error   <= timeout_s;
      read_4         <= read_8_next_s[31:0];
      read_8         <= read_8_next_s;
    end
  end

endmodule

// File: doc/read_responder.md
# read_responder

Memory-side responder for the read stage's data-read protocol. It accepts one read request at a time (linear address, length 1–8 bytes), splits it into up to three aligned dword beats on a pipelined Avalon-style bus, and reassembles the bytes. It returns the right-aligned, zero-extended result on `read_4`/`read_8` with a one-cycle done pulse. It sits between the read stage and the data-cache/memory arbiter.

## Interface
- No parameters.
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-high reset.
- `rd_req` input 1: level request; held until `rd_done`.
- `rd_address` input 32: linear byte address of the first byte.
- `rd_length` input 4: byte count 1–8; 0 and 9–15 are treated as 8.
- `rd_abort` input 1: pipeline flush; cancels the result of the current request.
- `rd_done` output 1: one-cycle pulse; `read_4`/`read_8` are valid in that cycle.
- `read_4` output 32: equals `read_8[31:0]`.
- `read_8` output 64: requested bytes right-aligned; bytes beyond `rd_length` are zero.
- `rd_busy` output 1: high in every state except IDLE.
- `rd_bus_error` output 1: one-cycle pulse on timeout (only when the timeout feature is compiled in).
- `bus_address` output 30: dword address.
- `bus_read` output 1: read command.
- `bus_byteenable` output 4: active bytes of the beat.
- `bus_waitrequest` input 1: command stall.
- `bus_readdatavalid` input 1: read data strobe.
- `bus_readdata` input 32: read data.

## Operation
- **States:** IDLE, REQ, WAIT, DONE.
- **Beat count:** on acceptance, latch `off = rd_address[1:0]`, effective length `len`, `beats = (off + len + 3) >> 2` (1..3), and `bus_address = rd_address[31:2]`.
- **IDLE:** when `rd_req=1` and `rd_abort=0`, latch the request and go to REQ. Otherwise stay.
- **REQ:** `bus_read=1`. When `bus_waitrequest=0`, the command is taken; go to WAIT. `bus_address`, `bus_byteenable` and `bus_read` stay stable while `bus_waitrequest=1`.
- **WAIT:** `bus_read=0`. On `bus_readdatavalid`, store `bus_readdata` in buffer slot `beat_idx` (96-bit buffer).
  - If this is not the last beat: increment `beat_idx`, increment `bus_address` modulo 2^30 (0x3FFFFFFF wraps to 0), and go to REQ.
  - If this is the last beat: go to DONE.
- **Byte enables:**
  - Single beat: bits `off .. off+len-1`.
  - First of several: bits `off..3`.
  - Middle: `4'b1111`.
  - Last: bits `0 .. ((off+len-1) mod 4)`.
- **DONE:**
  - `read_8 = (buffer >> (8*off))[63:0]` with bytes ≥ `len` masked to zero.
  - `rd_done=1` unless the abort flag is set.
  - Always go to IDLE.
- **Requester handshake:** the requester drops `rd_req` combinationally in the cycle `rd_done=1`. A new request is accepted in the following IDLE cycle.
- **Abort:**
  - In IDLE, `rd_abort` blocks acceptance.
  - In REQ or WAIT, `rd_abort` sets a sticky abort flag. The in-flight command and all of its beats still complete, because a command cannot be withdrawn under waitrequest.
  - On reaching DONE with the flag set, `rd_done` stays low and `read_4`/`read_8` keep their previous values; the flag clears in DONE.
- **Reset:** `rst` in any state forces IDLE and clears the abort flag. All outputs reset to 0: `bus_read`, `bus_address`, `bus_byteenable`, `rd_done`, `rd_busy`, `rd_bus_error`, `read_4`, `read_8`. Any beats still outstanding on the bus are ignored.

## Timing
- All outputs are registered.
- Minimum latency (acceptance cycle = 0, zero waitrequest, readdatavalid one cycle after the command is taken):
  - `bus_read` is high in cycle 1.
  - Data arrives in cycle 2.
  - `rd_done` is high in cycle 3.
- Each extra beat adds 2 cycles; each waitrequest cycle adds 1.
- `bus_readdatavalid` in the same cycle as command acceptance is illegal and is ignored.
- At most one command is outstanding at any time.
- `rd_done` and `rd_bus_error` are never high for more than one cycle.

## Configuration
- `READ_RESPONDER_TIMEOUT_EN` defined:
  - An 8-bit counter runs in WAIT and resets on entry to WAIT.
  - At 255 cycles without `bus_readdatavalid`, the current beat is filled with `32'hFFFFFFFF`, `rd_bus_error` pulses once, and the sequence continues as if the data had arrived.
- `READ_RESPONDER_TIMEOUT_EN` undefined:
  - No counter; WAIT holds indefinitely.
  - `rd_bus_error` is tied to 0.

## Test plan
- **Aligned dword:** address 0x00001000, length 4, data 0xAABBCCDD → one beat, byteenable 1111, `read_4=0xAABBCCDD`, `rd_done` in cycle 3.
- **Unaligned dword crossing a dword boundary:** address 0x00001003, length 4, beats 0x44332211 and 0x88776655 → byteenable 1000 then 0111, `read_4=0x77665544`.
- **Unaligned qword:** address 0x00002002, length 8 → three beats with byteenable 1100/1111/0011, bytes correctly assembled, latency 7 cycles.
- **Wrap and zero-extend:** address 0xFFFFFFFE, length 4 → `bus_address` 0x3FFFFFFF then 0x00000000. Separately, length 2 at offset 1 → `read_8[63:16]=0`.
- **Waitrequest and abort:** hold `bus_waitrequest` high 5 cycles → address and byteenable stable, latency +5. Assert `rd_abort` in WAIT → beats complete, no `rd_done`, `read_8` unchanged, next request served normally.
- **Timeout and reset (macro defined):** withhold data 255 cycles → `rd_bus_error` pulse, `read_4=0xFFFFFFFF`. Assert `rst` mid-REQ → every output 0 on the next cycle.
